// File: rtl/butterfly_unit.sv
// Pipelined CT/GS butterfly mod q with one Montgomery multiplier per stage.
// Stage 1 holds (a, mont(b,w)) for CT or (addq, subq) for GS; stage 2 finishes into the output registers.
module butterfly_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int LOG_R      = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    input  logic [DATA_WIDTH-1:0] w_i,
    input  logic [DATA_WIDTH-1:0] q_i,
    input  logic [LOG_R-1:0]      q_dash_i,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [DATA_WIDTH-1:0] a_o,
    output logic [DATA_WIDTH-1:0] b_o
);

    localparam int W  = DATA_WIDTH;
    localparam int MX = (W > LOG_R) ? W : LOG_R;
    // Wide enough for x*y + m*q without overflow.
    localparam int PW = W + MX + 1;

    function automatic logic [W-1:0] mont(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] q, input logic [LOG_R-1:0] qd);
        logic [PW-1:0]    t;
        logic [LOG_R-1:0] m;
        logic [PW-1:0]    s;
        t = PW'(x) * PW'(y);
        m = t[LOG_R-1:0] * qd;
        s = (t + PW'(m) * PW'(q)) >> LOG_R;
        if (s >= PW'(q)) s = s - PW'(q);
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] addq(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] q);
        logic [W:0] s;
        s = {1'b0, x} + {1'b0, y};
        if (s >= {1'b0, q}) s = s - {1'b0, q};
        return s[W-1:0];
    endfunction

    function automatic logic [W-1:0] subq(input logic [W-1:0] x, input logic [W-1:0] y,
                                          input logic [W-1:0] q);
        logic [W:0] d;
        d = {1'b0, x} - {1'b0, y};
        if (d[W]) d = d + {1'b0, q};
        return d[W-1:0];
    endfunction

    logic         r_v1;
    logic         r_mode;
    logic [W-1:0] r_x;
    logic [W-1:0] r_y;
    logic [W-1:0] r_w;
    logic         r_valid_o;
    logic [W-1:0] r_a_o;
    logic [W-1:0] r_b_o;

    logic         w_adv1;
    logic         w_adv2;
    logic [W-1:0] w_x1;
    logic [W-1:0] w_y1;
    logic [W-1:0] w_a2;
    logic [W-1:0] w_b2;

    always_comb begin
        w_adv2 = !r_valid_o || ready_i;
        w_adv1 = !r_v1 || w_adv2;
        if (mode_i) begin
            w_x1 = addq(a_i, b_i, q_i);
            w_y1 = subq(a_i, b_i, q_i);
        end else begin
            w_x1 = a_i;
            w_y1 = mont(b_i, w_i, q_i, q_dash_i);
        end
        if (r_mode) begin
            w_a2 = r_x;
            w_b2 = mont(r_y, r_w, q_i, q_dash_i);
        end else begin
            w_a2 = addq(r_x, r_y, q_i);
            w_b2 = subq(r_x, r_y, q_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_v1      <= 1'b0;
            r_mode    <= 1'b0;
            r_x       <= '0;
            r_y       <= '0;
            r_w       <= '0;
            r_valid_o <= 1'b0;
            r_a_o     <= '0;
            r_b_o     <= '0;
        end else begin
            if (w_adv1) begin
                r_v1 <= valid_i;
                if (valid_i) begin
                    r_mode <= mode_i;
                    r_x    <= w_x1;
                    r_y    <= w_y1;
                    r_w    <= w_i;
                end
            end
            if (w_adv2) begin
                r_valid_o <= r_v1;
                if (r_v1) begin
                    r_a_o <= w_a2;
                    r_b_o <= w_b2;
                end
            end
        end
    end

    assign ready_o = w_adv1;
    assign valid_o = r_valid_o;
    assign a_o     = r_a_o;
    assign b_o     = r_b_o;

endmodule
